// File: rtl/booth_divider_32_if.sv
// Handshake and result bundle between the arithmetic controller and the divider.
interface booth_divider_32_if #(
  parameter int WIDTH = 32
);
  logic                    start;
  logic signed [WIDTH-1:0] dividend;
  logic signed [WIDTH-1:0] divisor;
  logic signed [WIDTH-1:0] quotient;
  logic signed [WIDTH-1:0] remainder;
  logic                    busy;
  logic                    done;
  logic                    div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/booth_divider_32.sv
// Sequential signed divider: one restoring iteration per clock on a 2*WIDTH+1 bit
// shift/accumulate register, sign fix-up applied to the magnitudes at the end.
module booth_divider_32 #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  booth_divider_32_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH:0]     acc;
  logic [2*WIDTH:0]     acc_sh;
  logic [2*WIDTH:0]     acc_nxt;
  logic [WIDTH:0]       trial;
  logic                 fits;
  logic [WIDTH-1:0]     dmag;
  logic [CW-1:0]        cnt;
  logic                 sign_q;
  logic                 sign_r;
  logic                 dbz;
  logic [WIDTH-1:0]     quot_r;
  logic [WIDTH-1:0]     rem_r;
  logic                 done_r;
  logic                 dbz_out;

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1) without overflow.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.divisor == '0) ? FIX : CALC;
      CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration datapath: shift, trial subtract of the upper half, keep or restore.
  always_comb begin
    acc_sh  = {acc[2*WIDTH-1:0], 1'b0};
    fits    = acc_sh[2*WIDTH:WIDTH] >= {1'b0, dmag};
    trial   = acc_sh[2*WIDTH:WIDTH] - {1'b0, dmag};
    acc_nxt = fits ? {trial, acc_sh[WIDTH-1:1], 1'b1} : acc_sh;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      dmag    <= '0;
      cnt     <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      dbz     <= 1'b0;
      quot_r  <= '0;
      rem_r   <= '0;
      done_r  <= 1'b0;
      dbz_out <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            sign_r  <= bus.dividend[WIDTH-1];
            acc     <= {(WIDTH + 1)'(0), mag(bus.dividend)};
            dmag    <= mag(bus.divisor);
            dbz     <= (bus.divisor == '0);
            cnt     <= '0;
            dbz_out <= 1'b0;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          done_r <= 1'b1;
          // Divide-by-zero never iterated, so the low half still holds |dividend|.
          if (dbz) begin
            quot_r  <= '1;
            rem_r   <= apply_sign(sign_r, acc[WIDTH-1:0]);
            dbz_out <= 1'b1;
          end else begin
            quot_r  <= apply_sign(sign_q, acc[WIDTH-1:0]);
            rem_r   <= apply_sign(sign_r, acc[2*WIDTH-1:WIDTH]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_out;
endmodule

// File: tb/tb_booth_divider_32.sv
// Directed and randomized checks of booth_divider_32 against hand-computed results.
module tb_booth_divider_32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  booth_divider_32_if #(.WIDTH(32)) dif ();

  booth_divider_32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  // Launch one operation (caller is 1 time unit after a rising edge, DUT idle).
  // lat = edges after the start edge until done is seen (capped at 100).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit busy_ok);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    @(posedge clk); #1;
    dif.start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!dif.done && lat < 100) begin
      if (!dif.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (dif.quotient !== 32'h0) begin n_bad++; $display("FAIL reset_quotient got %h want 0", dif.quotient); end
    n_cmp++; if (dif.remainder !== 32'h0) begin n_bad++; $display("FAIL reset_remainder got %h want 0", dif.remainder); end
    n_cmp++; if (dif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", dif.busy); end
    n_cmp++; if (dif.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", dif.done); end
    n_cmp++; if (dif.div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dbz got %b want 0", dif.div_by_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; bit busy_ok;
    run_op(32'd100, 32'd7, lat, busy_ok);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL basic_latency got %0d want 33", lat); end
    n_cmp++; if (!busy_ok) begin n_bad++; $display("FAIL basic_busy_during got 0 want 1"); end
    n_cmp++; if (dif.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", dif.busy); end
    n_cmp++; if (dif.quotient !== 32'd14) begin n_bad++; $display("FAIL basic_quotient got %h want 0000000e", dif.quotient); end
    n_cmp++; if (dif.remainder !== 32'd2) begin n_bad++; $display("FAIL basic_remainder got %h want 00000002", dif.remainder); end
    n_cmp++; if (dif.div_by_zero !== 1'b0) begin n_bad++; $display("FAIL basic_dbz got %b want 0", dif.div_by_zero); end
    @(posedge clk); #1;
    n_cmp++; if (dif.done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got %b want 0", dif.done); end
    n_cmp++; if (dif.quotient !== 32'd14) begin n_bad++; $display("FAIL basic_quotient_hold got %h want 0000000e", dif.quotient); end
  endtask

  task automatic test_signs();
    logic [31:0] va [3] = '{32'hFFFFFF9C, 32'd100,    32'hFFFFFF9C};
    logic [31:0] vb [3] = '{32'd7,        32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] vq [3] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14};
    logic [31:0] vr [3] = '{32'hFFFFFFFE, 32'd2,      32'hFFFFFFFE};
    int lat; bit busy_ok;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], lat, busy_ok);
      n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL signs_latency[%0d] got %0d want 33", i, lat); end
      n_cmp++; if (dif.quotient !== vq[i]) begin n_bad++; $display("FAIL signs_quotient[%0d] got %h want %h", i, dif.quotient, vq[i]); end
      n_cmp++; if (dif.remainder !== vr[i]) begin n_bad++; $display("FAIL signs_remainder[%0d] got %h want %h", i, dif.remainder, vr[i]); end
    end
  endtask

  task automatic test_div_zero();
    int lat; bit busy_ok;
    run_op(32'd7, 32'd0, lat, busy_ok);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL dbz_latency got %0d want 1", lat); end
    n_cmp++; if (dif.div_by_zero !== 1'b1) begin n_bad++; $display("FAIL dbz_flag got %b want 1", dif.div_by_zero); end
    n_cmp++; if (dif.quotient !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL dbz_quotient got %h want ffffffff", dif.quotient); end
    n_cmp++; if (dif.remainder !== 32'd7) begin n_bad++; $display("FAIL dbz_remainder got %h want 00000007", dif.remainder); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (dif.div_by_zero !== 1'b1) begin n_bad++; $display("FAIL dbz_hold got %b want 1", dif.div_by_zero); end
    // Negative dividend by zero returns the dividend unchanged.
    run_op(32'hFFFFFF9C, 32'd0, lat, busy_ok);
    n_cmp++; if (dif.remainder !== 32'hFFFFFF9C) begin n_bad++; $display("FAIL dbz_neg_remainder got %h want ffffff9c", dif.remainder); end
    dif.start = 1'b1; dif.dividend = 32'd5; dif.divisor = 32'd5;
    @(posedge clk); #1;
    dif.start = 1'b0;
    n_cmp++; if (dif.div_by_zero !== 1'b0) begin n_bad++; $display("FAIL dbz_clear_on_start got %b want 0", dif.div_by_zero); end
    lat = 0;
    while (!dif.done && lat < 100) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (dif.quotient !== 32'd1 || dif.remainder !== 32'd0) begin n_bad++; $display("FAIL dbz_next_result got %h r %h want 00000001 r 00000000", dif.quotient, dif.remainder); end
  endtask

  task automatic test_boundaries();
    logic [31:0] va [3] = '{32'h80000000, 32'h80000000, 32'd0};
    logic [31:0] vb [3] = '{32'hFFFFFFFF, 32'd1,        32'd5};
    logic [31:0] vq [3] = '{32'h80000000, 32'h80000000, 32'd0};
    int lat; bit busy_ok;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], lat, busy_ok);
      n_cmp++; if (dif.quotient !== vq[i]) begin n_bad++; $display("FAIL bound_quotient[%0d] got %h want %h", i, dif.quotient, vq[i]); end
      n_cmp++; if (dif.remainder !== 32'd0) begin n_bad++; $display("FAIL bound_remainder[%0d] got %h want 00000000", i, dif.remainder); end
      n_cmp++; if (dif.div_by_zero !== 1'b0) begin n_bad++; $display("FAIL bound_dbz[%0d] got %b want 0", i, dif.div_by_zero); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    dif.start = 1'b1; dif.dividend = 32'd1000; dif.divisor = 32'd3;
    @(posedge clk); #1;
    dif.start = 1'b0;
    lat = 0;
    while (!dif.done && lat < 100) begin
      if (lat == 5) begin dif.start = 1'b1; dif.dividend = 32'd9; dif.divisor = 32'd2; end
      else dif.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL b2b_first_latency got %0d want 33", lat); end
    n_cmp++; if (dif.quotient !== 32'd333 || dif.remainder !== 32'd1) begin n_bad++; $display("FAIL b2b_first_result got %0d r %0d want 333 r 1", dif.quotient, dif.remainder); end
    // Start raised in the done cycle must be accepted.
    dif.start = 1'b1; dif.dividend = 32'd9; dif.divisor = 32'd2;
    @(posedge clk); #1;
    dif.start = 1'b0;
    n_cmp++; if (dif.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_busy got %b want 1", dif.busy); end
    lat = 0;
    while (!dif.done && lat < 100) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL b2b_second_latency got %0d want 33", lat); end
    n_cmp++; if (dif.quotient !== 32'd4 || dif.remainder !== 32'd1) begin n_bad++; $display("FAIL b2b_second_result got %0d r %0d want 4 r 1", dif.quotient, dif.remainder); end
  endtask

  task automatic test_reset_mid();
    int lat; bit busy_ok; int seen_done;
    dif.start = 1'b1; dif.dividend = 32'd1000; dif.divisor = 32'd3;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (dif.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", dif.busy); end
    n_cmp++; if (dif.quotient !== 32'd0 || dif.remainder !== 32'd0) begin n_bad++; $display("FAIL midrst_results got %h r %h want 0 r 0", dif.quotient, dif.remainder); end
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (dif.done) seen_done++;
    end
    n_cmp++; if (seen_done !== 0) begin n_bad++; $display("FAIL midrst_no_done got %0d pulses want 0", seen_done); end
    run_op(32'd50, 32'd6, lat, busy_ok);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL midrst_next_latency got %0d want 33", lat); end
    n_cmp++; if (dif.quotient !== 32'd8 || dif.remainder !== 32'd2) begin n_bad++; $display("FAIL midrst_next_result got %0d r %0d want 8 r 2", dif.quotient, dif.remainder); end
  endtask

  task automatic test_random();
    int lat; bit busy_ok;
    logic [31:0] a, b;
    longint la, lb, lq, lr, aq, ar, abr, abb;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) begin
        a = $urandom();
        b = $urandom();
      end else begin
        a = $urandom_range(2000, 0) - 1000;
        b = $urandom_range(40, 0) - 20;
      end
      if (b == 32'd0) b = 32'd3;
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd7;
      run_op(a, b, lat, busy_ok);
      la = longint'($signed(a)); lb = longint'($signed(b));
      lq = la / lb; lr = la % lb;
      n_cmp++; if (dif.quotient !== lq[31:0] || dif.remainder !== lr[31:0]) begin
        n_bad++; $display("FAIL rand_result[%0d] %h/%h got %h r %h want %h r %h", i, a, b, dif.quotient, dif.remainder, lq[31:0], lr[31:0]);
      end
      aq = longint'($signed(dif.quotient)); ar = longint'($signed(dif.remainder));
      abr = (ar < 0) ? -ar : ar; abb = (lb < 0) ? -lb : lb;
      n_cmp++; if (aq * lb + ar != la || abr >= abb) begin
        n_bad++; $display("FAIL rand_identity[%0d] %h/%h got q %h r %h want q*d+r=a and |r|<|d|", i, a, b, dif.quotient, dif.remainder);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
